exec_mult: RTL and testbench
============================

EXEC_MULT -- requirements
Module: exec_mult

Interface
REQ-001 SHALL have a single clock domain and a synchronous, active-high reset.
REQ-002 Parameter: STAGES, default 4, is the number of pipeline stages from issue accept to the CDB-request register; legal range 2..6.
REQ-003 Port: clk  input  1  clock; all state updates on the rising edge.
REQ-004 Port: rst  input  1  synchronous active-high reset.
REQ-005 Port: issue_valid  input  1  the multiply issue queue presents an instruction.
REQ-006 Port: issue_rsdata  input  32  operand A.
REQ-007 Port: issue_rtdata  input  32  operand B.
REQ-008 Port: issue_tag  input  6  destination ROB/rename tag.
REQ-009 Port: issue_ready  output  1  unit accepts the instruction this cycle.
REQ-010 Port: flush  input  1  branch-mispredict kill of all in-flight operations.
REQ-011 Port: cdb_req  output  1  final stage holds a result awaiting broadcast.
REQ-012 Port: cdb_grant  input  1  CDB arbiter grant for this unit.
REQ-013 Port: cdb_data  output  32  result value.
REQ-014 Port: cdb_tag  output  6  result tag.
REQ-015 Port: cdb_valid  output  1  broadcast qualifier; high only when granted.
REQ-016 Port: busy  output  1  at least one stage holds a valid operation.

Function
REQ-017 The unit SHALL compute the low 32 bits of rsdata*rtdata; the result is identical for signed and unsigned operands, and upper bits are discarded.
REQ-018 Each stage k (1..STAGES) SHALL hold a valid bit, a 6-bit tag, and the partial or complete product.
REQ-019 The issue handshake SHALL transfer an operation only on a cycle where issue_valid and issue_ready are both high.
REQ-020 issue_ready SHALL equal NOT(stage-1 valid) OR (stage 1 advances this cycle); it SHALL be combinational with no dependence on issue_valid.
REQ-021 Stage k (k less than STAGES) SHALL advance when stage k+1 is empty or stage k+1 advances this cycle (bubble collapse).
REQ-022 The final stage SHALL advance (empty or refill) only when cdb_grant is high.
REQ-023 An operation accepted at edge N with no back-pressure SHALL appear in the final stage after edge N+STAGES-1; cdb_req SHALL be high in that cycle (latency STAGES).
REQ-024 cdb_req SHALL equal final-stage valid, and cdb_data and cdb_tag SHALL equal the final-stage contents.
REQ-025 cdb_valid SHALL equal cdb_req AND cdb_grant; cdb_data and cdb_tag are don't-care while cdb_valid is low.
REQ-026 A granted result SHALL be broadcast exactly once; the stage SHALL clear or refill at the grant edge.
REQ-027 While the final stage waits without a grant, its contents SHALL hold stable every cycle.
REQ-028 Upstream stages SHALL keep advancing into bubbles during back-pressure; with all stages full and no grant, issue_ready SHALL be 0.
REQ-029 Throughput SHALL be one operation per cycle with continuous grant; no operation SHALL ever be dropped or duplicated.
REQ-030 flush SHALL clear every valid bit at the edge it is sampled, and SHALL block any issue accept in the same cycle.
REQ-031 cdb_valid SHALL still be asserted in the flush cycle if the final stage is valid and granted.
REQ-032 busy SHALL equal the OR of all stage valid bits.
REQ-033 A grant received while cdb_req is low SHALL be ignored.

Reset
REQ-034 On rst, all stage valid bits SHALL clear; data and tag registers need no reset.
REQ-035 With rst held, outputs SHALL be: cdb_req=0, cdb_valid=0, busy=0, issue_ready=1.
REQ-036 rst SHALL take priority over flush, issue, and grant, including when asserted mid-operation.
REQ-037 The first accept SHALL be possible in the first cycle after rst deasserts.

Verification
REQ-038 Single op, cdb_grant tied 1: issue 7 x 6, tag 0x15 at edge N -> cdb_valid=1, cdb_data=42, cdb_tag=0x15 in the cycle after edge N+3; busy=0 afterwards.
REQ-039 Signed/overflow check: 0xFFFFFFFF x 0x00000003 -> cdb_data=0xFFFFFFFD; 0x00010000 x 0x00010000 -> cdb_data=0.
REQ-040 Back-pressure: issue 6 back-to-back ops with cdb_grant=0 -> issue_ready drops after the 4th accept, final stage holds the first op stable; then raise grant -> all 6 broadcast in order on consecutive cycles with correct tags.
REQ-041 Bubble collapse: issue 2 ops with a 2-cycle gap while the final stage is stalled -> they become adjacent; no tag is lost or duplicated.
REQ-042 Flush: with 3 ops in flight, pulse flush -> busy=0 on the next cycle, no later cdb_req, and an issue_valid in the flush cycle is not accepted.
REQ-043 Reset mid-stream: with the pipeline full and stalled, assert rst for 1 cycle -> cdb_req=0 and issue_ready=1 on the next cycle, with no stale broadcast afterwards.

Source files
------------

// File: rtl/exec_mult.sv
// Pipelined 32x32 -> low-32 multiplier execution unit.
// Operations enter from the issue queue, travel through STAGES elastic
// stages and leave through a CDB request/grant handshake. Each stage
// advances whenever the stage in front of it is empty or is itself moving,
// so bubbles collapse while the final stage waits for a grant.
// The product is split across the first two stages: stage 1 forms the
// low 16x16 partial product and the folded cross terms, and stage 2 adds
// them. Later stages only carry the finished result forward.
// STAGES is intended to be in the range 2..6.
module exec_mult #(
    parameter int STAGES = 4
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        issue_valid,
    input  logic [31:0] issue_rsdata,
    input  logic [31:0] issue_rtdata,
    input  logic [5:0]  issue_tag,
    output logic        issue_ready,
    input  logic        flush,
    output logic        cdb_req,
    input  logic        cdb_grant,
    output logic [31:0] cdb_data,
    output logic [5:0]  cdb_tag,
    output logic        cdb_valid,
    output logic        busy
);

    localparam int S = STAGES;

    // Per-stage state: valid bit, tag and (partial) product.
    logic [S:1]  valid_q;
    logic [S:1]  valid_d;
    logic [31:0] data_q [1:S];
    logic [31:0] data_d [1:S];
    logic [5:0]  tag_q  [1:S];
    logic [5:0]  tag_d  [1:S];

    // Stage 1 also keeps the folded cross terms, which only affect the
    // upper half of the low 32 result bits.
    logic [15:0] cross_q;
    logic [15:0] cross_d;

    // free[k]: stage k can take new content at this edge.
    // leave[k]: the operation in stage k moves on at this edge.
    logic [S:1]  free;
    logic [S:1]  leave;

    logic        accept;
    logic [31:0] pp_ll;
    logic [15:0] pp_cross;

    // Partial products of the incoming operands. Only the low 32 bits of
    // the full product are needed, so the hi*hi term never contributes and
    // the cross terms are only needed modulo 2^16.
    always_comb begin
        pp_ll    = {16'h0000, issue_rsdata[15:0]} * {16'h0000, issue_rtdata[15:0]};
        pp_cross = (issue_rsdata[15:0] * issue_rtdata[31:16])
                 + (issue_rsdata[31:16] * issue_rtdata[15:0]);
    end

    // Ripple the advance condition from the CDB end back to the issue end.
    always_comb begin
        free  = '0;
        leave = '0;
        leave[S] = valid_q[S] & cdb_grant;
        free[S]  = ~valid_q[S] | leave[S];
        for (int k = S - 1; k >= 1; k--) begin
            leave[k] = valid_q[k] & free[k + 1];
            free[k]  = ~valid_q[k] | leave[k];
        end
    end

    // Handshake: ready depends only on pipeline state and grant; a flush
    // suppresses the transfer itself.
    always_comb begin
        issue_ready = free[1];
        accept      = issue_valid & free[1] & ~flush;
    end

    // Next valid bits: each free stage takes the valid bit of the stage
    // behind it; flush kills everything in flight.
    always_comb begin
        valid_d = valid_q;
        if (free[1]) begin
            valid_d[1] = accept;
        end
        for (int k = 2; k <= S; k++) begin
            if (free[k]) begin
                valid_d[k] = valid_q[k - 1];
            end
        end
        if (flush) begin
            valid_d = '0;
        end
    end

    // Next payload: load only when a valid operation actually moves in, so
    // a stalled stage keeps its contents unchanged.
    always_comb begin
        cross_d = cross_q;
        for (int k = 1; k <= S; k++) begin
            data_d[k] = data_q[k];
            tag_d[k]  = tag_q[k];
        end
        if (accept) begin
            data_d[1] = pp_ll;
            tag_d[1]  = issue_tag;
            cross_d   = pp_cross;
        end
        for (int k = 2; k <= S; k++) begin
            if (free[k] && valid_q[k - 1]) begin
                tag_d[k] = tag_q[k - 1];
                if (k == 2) begin
                    data_d[k] = data_q[1] + {cross_q, 16'h0000};
                end else begin
                    data_d[k] = data_q[k - 1];
                end
            end
        end
    end

    // Valid bits are the only state that needs a reset.
    always_ff @(posedge clk) begin
        if (rst) begin
            valid_q <= '0;
        end else begin
            valid_q <= valid_d;
        end
    end

    // Payload registers; meaningless while the matching valid bit is low.
    always_ff @(posedge clk) begin
        cross_q <= cross_d;
        for (int k = 1; k <= S; k++) begin
            data_q[k] <= data_d[k];
            tag_q[k]  <= tag_d[k];
        end
    end

    // Result broadcast and status.
    always_comb begin
        cdb_req   = valid_q[S];
        cdb_data  = data_q[S];
        cdb_tag   = tag_q[S];
        cdb_valid = valid_q[S] & cdb_grant;
        busy      = |valid_q;
    end

endmodule

// File: tb/tb_exec_mult.sv
// Self-checking bench for exec_mult with a scoreboard reference model.
module tb_exec_mult;

    localparam int STAGES = 4;

    logic        clk = 1'b0;
    logic        rst;
    logic        issue_valid;
    logic [31:0] issue_rsdata;
    logic [31:0] issue_rtdata;
    logic [5:0]  issue_tag;
    logic        issue_ready;
    logic        flush;
    logic        cdb_req;
    logic        cdb_grant;
    logic [31:0] cdb_data;
    logic [5:0]  cdb_tag;
    logic        cdb_valid;
    logic        busy;

    int n_checks = 0;
    int n_fail   = 0;

    typedef struct packed {
        logic [5:0]  tag;
        logic [31:0] data;
    } op_t;

    op_t sb[$];

    exec_mult #(.STAGES(STAGES)) dut (
        .clk          (clk),
        .rst          (rst),
        .issue_valid  (issue_valid),
        .issue_rsdata (issue_rsdata),
        .issue_rtdata (issue_rtdata),
        .issue_tag    (issue_tag),
        .issue_ready  (issue_ready),
        .flush        (flush),
        .cdb_req      (cdb_req),
        .cdb_grant    (cdb_grant),
        .cdb_data     (cdb_data),
        .cdb_tag      (cdb_tag),
        .cdb_valid    (cdb_valid),
        .busy         (busy)
    );

    always #5 clk = ~clk;

    // Reference: full 64-bit product, keep the low word.
    function automatic logic [31:0] ref_mul(input logic [31:0] a, input logic [31:0] b);
        logic [63:0] p;
        p = {32'h0, a} * {32'h0, b};
        return p[31:0];
    endfunction

    task automatic next_cycle();
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        rst = 1'b1; issue_valid = 1'b0; flush = 1'b0; cdb_grant = 1'b0;
        issue_rsdata = '0; issue_rtdata = '0; issue_tag = '0;
        repeat (2) @(posedge clk);
        #1;
        @(negedge clk);
        n_checks++; if (cdb_req !== 1'b0) begin n_fail++; $display("FAIL reset_cdb_req got=%b exp=0", cdb_req); end
        n_checks++; if (cdb_valid !== 1'b0) begin n_fail++; $display("FAIL reset_cdb_valid got=%b exp=0", cdb_valid); end
        n_checks++; if (busy !== 1'b0) begin n_fail++; $display("FAIL reset_busy got=%b exp=0", busy); end
        n_checks++; if (issue_ready !== 1'b1) begin n_fail++; $display("FAIL reset_issue_ready got=%b exp=1", issue_ready); end
        next_cycle();
        rst = 1'b0;
    endtask

    // 7 x 6, grant tied high: result visible in the cycle after edge N+3.
    task automatic test_single();
        cdb_grant = 1'b1;
        issue_valid = 1'b1; issue_rsdata = 32'd7; issue_rtdata = 32'd6; issue_tag = 6'h15;
        @(negedge clk);
        n_checks++; if (issue_ready !== 1'b1) begin n_fail++; $display("FAIL single_first_ready got=%b exp=1", issue_ready); end
        next_cycle();
        issue_valid = 1'b0;
        for (int i = 0; i < STAGES; i++) begin
            @(negedge clk);
            if (i < STAGES - 1) begin
                n_checks++; if (cdb_req !== 1'b0) begin n_fail++; $display("FAIL single_early_req cycle=%0d got=%b exp=0", i, cdb_req); end
            end else begin
                n_checks++; if (cdb_valid !== 1'b1) begin n_fail++; $display("FAIL single_cdb_valid got=%b exp=1", cdb_valid); end
                n_checks++; if (cdb_data !== 32'd42) begin n_fail++; $display("FAIL single_cdb_data got=%0d exp=42", cdb_data); end
                n_checks++; if (cdb_tag !== 6'h15) begin n_fail++; $display("FAIL single_cdb_tag got=%h exp=15", cdb_tag); end
                $display("broadcast tag=%h data=%0d", cdb_tag, cdb_data);
            end
            next_cycle();
        end
        @(negedge clk);
        n_checks++; if (busy !== 1'b0) begin n_fail++; $display("FAIL single_busy_after got=%b exp=0", busy); end
        n_checks++; if (cdb_req !== 1'b0) begin n_fail++; $display("FAIL single_req_after got=%b exp=0", cdb_req); end
        next_cycle();
    endtask

    task automatic test_overflow();
        logic [31:0] va [2];
        logic [31:0] vb [2];
        logic [31:0] ve [2];
        bit seen;
        va[0] = 32'hFFFF_FFFF; vb[0] = 32'h0000_0003; ve[0] = 32'hFFFF_FFFD;
        va[1] = 32'h0001_0000; vb[1] = 32'h0001_0000; ve[1] = 32'h0000_0000;
        cdb_grant = 1'b1;
        for (int v = 0; v < 2; v++) begin
            issue_valid = 1'b1; issue_rsdata = va[v]; issue_rtdata = vb[v]; issue_tag = 6'(v + 1);
            next_cycle();
            issue_valid = 1'b0;
            seen = 1'b0;
            for (int c = 0; c < 12 && !seen; c++) begin
                @(negedge clk);
                if (cdb_valid) begin
                    seen = 1'b1;
                    $display("broadcast tag=%h data=%h", cdb_tag, cdb_data);
                    n_checks++; if (cdb_data !== ve[v]) begin n_fail++; $display("FAIL overflow_data vec=%0d got=%h exp=%h", v, cdb_data, ve[v]); end
                end
                next_cycle();
            end
            n_checks++; if (!seen) begin n_fail++; $display("FAIL overflow_timeout vec=%0d got=none exp=broadcast", v); end
        end
    endtask

    task automatic test_back_pressure();
        int sent = 0;
        int got = 0;
        int stall = 0;
        int first = -1;
        int last = -1;
        cdb_grant = 1'b0;
        for (int c = 0; c < 60 && got < 6; c++) begin
            issue_valid  = (sent < 6);
            issue_rsdata = 32'(sent + 2);
            issue_rtdata = 32'(sent + 11) | 32'hABC0_0000;
            issue_tag    = 6'(32 + sent);
            @(negedge clk);
            if (sent == 4 && !cdb_grant) begin
                stall++;
                n_checks++; if (issue_ready !== 1'b0) begin n_fail++; $display("FAIL bp_ready_full got=%b exp=0", issue_ready); end
                n_checks++; if (cdb_req !== 1'b1 || cdb_tag !== 6'd32 || cdb_data !== ref_mul(32'd2, 32'd11 | 32'hABC0_0000)) begin
                    n_fail++; $display("FAIL bp_hold_first got=%b/%h/%h exp=1/20/%h", cdb_req, cdb_tag, cdb_data, ref_mul(32'd2, 32'd11 | 32'hABC0_0000));
                end
            end
            if (cdb_valid) begin
                $display("broadcast tag=%h data=%h", cdb_tag, cdb_data);
                n_checks++; if (cdb_tag !== 6'(32 + got) || cdb_data !== ref_mul(32'(got + 2), 32'(got + 11) | 32'hABC0_0000)) begin
                    n_fail++; $display("FAIL bp_order idx=%0d got=%h/%h exp=%h/%h", got, cdb_tag, cdb_data, 6'(32 + got), ref_mul(32'(got + 2), 32'(got + 11) | 32'hABC0_0000));
                end
                if (first < 0) first = c;
                last = c;
                got++;
            end
            if (issue_valid && issue_ready) sent++;
            if (!cdb_grant) begin
                n_checks++; if (sent > 4) begin n_fail++; $display("FAIL bp_overaccept got=%0d exp<=4", sent); end
            end
            next_cycle();
            if (stall == 3) cdb_grant = 1'b1;
        end
        issue_valid = 1'b0;
        n_checks++; if (got != 6) begin n_fail++; $display("FAIL bp_count got=%0d exp=6", got); end
        n_checks++; if (last - first != 5) begin n_fail++; $display("FAIL bp_consecutive got=%0d exp=5", last - first); end
    endtask

    task automatic test_bubble_collapse();
        int got = 0;
        int first = -1;
        int last = -1;
        for (int c = 0; c < 30 && got < 2; c++) begin
            issue_valid  = (c == 0 || c == 3);
            issue_rsdata = (c == 0) ? 32'd1000 : 32'd3;
            issue_rtdata = (c == 0) ? 32'd1000 : 32'd5;
            issue_tag    = (c == 0) ? 6'h2A : 6'h2B;
            cdb_grant    = (c >= 9);
            @(negedge clk);
            if (c == 3) begin
                n_checks++; if (issue_ready !== 1'b1) begin n_fail++; $display("FAIL bubble_ready got=%b exp=1", issue_ready); end
            end
            if (c == 8) begin
                n_checks++; if (cdb_req !== 1'b1 || cdb_tag !== 6'h2A) begin n_fail++; $display("FAIL bubble_head got=%b/%h exp=1/2a", cdb_req, cdb_tag); end
            end
            if (cdb_valid) begin
                $display("broadcast tag=%h data=%0d", cdb_tag, cdb_data);
                n_checks++;
                if (got == 0 && (cdb_tag !== 6'h2A || cdb_data !== 32'd1000000)) begin
                    n_fail++; $display("FAIL bubble_first got=%h/%0d exp=2a/1000000", cdb_tag, cdb_data);
                end else if (got == 1 && (cdb_tag !== 6'h2B || cdb_data !== 32'd15)) begin
                    n_fail++; $display("FAIL bubble_second got=%h/%0d exp=2b/15", cdb_tag, cdb_data);
                end
                if (first < 0) first = c;
                last = c;
                got++;
            end
            next_cycle();
        end
        issue_valid = 1'b0;
        n_checks++; if (got != 2) begin n_fail++; $display("FAIL bubble_count got=%0d exp=2", got); end
        n_checks++; if (last - first != 1) begin n_fail++; $display("FAIL bubble_adjacent got=%0d exp=1", last - first); end
    endtask

    task automatic test_flush();
        cdb_grant = 1'b0;
        for (int i = 0; i < 3; i++) begin
            issue_valid = 1'b1; issue_rsdata = 32'(i + 9); issue_rtdata = 32'd4; issue_tag = 6'(i + 5);
            next_cycle();
        end
        flush = 1'b1; issue_valid = 1'b1; issue_tag = 6'h3F;
        next_cycle();
        flush = 1'b0; issue_valid = 1'b0; cdb_grant = 1'b1;
        @(negedge clk);
        n_checks++; if (busy !== 1'b0) begin n_fail++; $display("FAIL flush_busy got=%b exp=0", busy); end
        for (int c = 0; c < 8; c++) begin
            if (c > 0) @(negedge clk);
            n_checks++; if (cdb_req !== 1'b0) begin n_fail++; $display("FAIL flush_late_req cycle=%0d got=%b exp=0", c, cdb_req); end
            next_cycle();
        end
    endtask

    task automatic test_reset_mid();
        bit full = 1'b0;
        cdb_grant = 1'b0;
        for (int c = 0; c < 12 && !full; c++) begin
            issue_valid = 1'b1; issue_rsdata = 32'(c + 100); issue_rtdata = 32'd7; issue_tag = 6'(c + 16);
            @(negedge clk);
            if (!issue_ready) full = 1'b1;
            next_cycle();
        end
        n_checks++; if (!full) begin n_fail++; $display("FAIL rstmid_fill got=notfull exp=full"); end
        rst = 1'b1; issue_valid = 1'b1; cdb_grant = 1'b1; flush = 1'b1;
        next_cycle();
        rst = 1'b0; issue_valid = 1'b0; flush = 1'b0;
        @(negedge clk);
        n_checks++; if (cdb_req !== 1'b0) begin n_fail++; $display("FAIL rstmid_req got=%b exp=0", cdb_req); end
        n_checks++; if (issue_ready !== 1'b1) begin n_fail++; $display("FAIL rstmid_ready got=%b exp=1", issue_ready); end
        n_checks++; if (busy !== 1'b0) begin n_fail++; $display("FAIL rstmid_busy got=%b exp=0", busy); end
        next_cycle();
        for (int c = 0; c < 8; c++) begin
            @(negedge clk);
            n_checks++; if (cdb_valid !== 1'b0) begin n_fail++; $display("FAIL rstmid_stale cycle=%0d got=%b exp=0", c, cdb_valid); end
            next_cycle();
        end
    endtask

    // Random traffic against an in-order scoreboard of in-flight results.
    task automatic test_random();
        op_t  hold;
        op_t  exp_op;
        bit   prev_hold = 1'b0;
        bit   drain;
        logic [5:0] tag_ctr = 6'd0;
        sb.delete();
        for (int c = 0; c < 1600; c++) begin
            drain        = (c >= 1570);
            issue_valid  = !drain && ($urandom_range(0, 9) < 7);
            issue_rsdata = ($urandom_range(0, 7) == 0) ? 32'hFFFF_FFFF : $urandom();
            issue_rtdata = ($urandom_range(0, 7) == 0) ? 32'h8000_0000 : $urandom();
            issue_tag    = tag_ctr;
            tag_ctr      = tag_ctr + 6'd1;
            cdb_grant    = drain || ($urandom_range(0, 9) < 6);
            flush        = !drain && ($urandom_range(0, 49) == 0);
            @(negedge clk);
            if (prev_hold) begin
                n_checks++; if (cdb_req !== 1'b1 || cdb_tag !== hold.tag || cdb_data !== hold.data) begin
                    n_fail++; $display("FAIL rnd_hold cycle=%0d got=%b/%h/%h exp=1/%h/%h", c, cdb_req, cdb_tag, cdb_data, hold.tag, hold.data);
                end
            end
            if (cdb_grant) begin
                n_checks++; if (issue_ready !== 1'b1) begin n_fail++; $display("FAIL rnd_ready_granted cycle=%0d got=%b exp=1", c, issue_ready); end
            end
            n_checks++; if (busy !== (sb.size() != 0)) begin n_fail++; $display("FAIL rnd_busy cycle=%0d got=%b exp=%b", c, busy, sb.size() != 0); end
            if (cdb_valid === 1'b1) begin
                n_checks++;
                if (sb.size() == 0) begin
                    n_fail++; $display("FAIL rnd_spurious cycle=%0d got=%h/%h exp=none", c, cdb_tag, cdb_data);
                end else begin
                    exp_op = sb.pop_front();
                    if (cdb_tag !== exp_op.tag || cdb_data !== exp_op.data) begin
                        n_fail++; $display("FAIL rnd_result cycle=%0d got=%h/%h exp=%h/%h", c, cdb_tag, cdb_data, exp_op.tag, exp_op.data);
                    end
                end
            end
            prev_hold = cdb_req && !cdb_grant && !flush;
            hold.tag  = cdb_tag;
            hold.data = cdb_data;
            if (flush) begin
                sb.delete();
            end else if (issue_valid && issue_ready) begin
                sb.push_back({issue_tag, ref_mul(issue_rsdata, issue_rtdata)});
            end
            next_cycle();
        end
        n_checks++; if (sb.size() != 0) begin n_fail++; $display("FAIL rnd_drain got=%0d exp=0", sb.size()); end
        $display("random phase complete");
    endtask

    initial begin
        test_reset();
        test_single();
        test_overflow();
        test_back_pressure();
        test_bubble_collapse();
        test_flush();
        test_reset_mid();
        test_random();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
